// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline skid buffer.
package pipe_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_BUSY  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned OCC_W      = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/pipe_reg_rst.sv
// Enable-gated data register with asynchronous active-low clear.
module pipe_reg_rst #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry elastic stage: main register drives m_data, skid register absorbs
// the one word accepted while the downstream stalls.
module pipe_skid_buffer
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       occupancy
);

    skid_state_e      state_q;
    skid_state_e      state_d;
    logic             in_fire;
    logic             out_fire;
    logic             main_en;
    logic             skid_en;
    logic             main_from_skid;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;

    assign in_fire  = s_valid & s_ready;
    assign out_fire = m_valid & m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SKID_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Load enables are gated by flush so a discarded input never lands in storage.
    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = SKID_EMPTY;
        end else begin
            unique case (state_q)
                SKID_EMPTY: begin
                    if (in_fire) begin
                        state_d = SKID_BUSY;
                        main_en = 1'b1;
                    end
                end
                SKID_BUSY: begin
                    if (in_fire && !out_fire) begin
                        state_d = SKID_FULL;
                        skid_en = 1'b1;
                    end else if (!in_fire && out_fire) begin
                        state_d = SKID_EMPTY;
                    end else if (in_fire && out_fire) begin
                        main_en = 1'b1;
                    end
                end
                SKID_FULL: begin
                    if (out_fire) begin
                        state_d        = SKID_BUSY;
                        main_en        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

    // Handshake outputs decode only the state flop, never the live inputs.
    always_comb begin
        m_valid   = 1'b0;
        s_ready   = 1'b1;
        occupancy = 2'd0;
        unique case (state_q)
            SKID_EMPTY: begin
                m_valid   = 1'b0;
                s_ready   = 1'b1;
                occupancy = 2'd0;
            end
            SKID_BUSY: begin
                m_valid   = 1'b1;
                s_ready   = 1'b1;
                occupancy = 2'd1;
            end
            SKID_FULL: begin
                m_valid   = 1'b1;
                s_ready   = 1'b0;
                occupancy = OCC_W'(SKID_DEPTH);
            end
            default: begin
                m_valid   = 1'b0;
                s_ready   = 1'b1;
                occupancy = 2'd0;
            end
        endcase
    end

    assign main_d = main_from_skid ? skid_q : s_data;

    pipe_reg_rst #(.WIDTH(WIDTH)) u_main_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (main_en),
        .d     (main_d),
        .q     (m_data)
    );

    pipe_reg_rst #(.WIDTH(WIDTH)) u_skid_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (skid_en),
        .d     (s_data),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Self-checking bench: queue-based reference model of a two-deep FIFO stage.
module tb_pipe_skid_buffer;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [1:0] occupancy;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [7:0]  q[$];

    pipe_skid_buffer #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .occupancy (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock edge, updating the model from its own view of readiness.
    task automatic step();
        bit acc;
        bit emit;
        acc  = s_valid && (q.size() < 2);
        emit = (q.size() > 0) && m_ready;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (emit) void'(q.pop_front());
            if (acc) q.push_back(s_data);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        q.delete();
        #1;
        n_checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b exp 0", m_valid); else n_pass++;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b exp 1", s_ready); else n_pass++;
        n_checks++; if (occupancy !== 2'd0) $display("FAIL reset_occ: got %0d exp 0", occupancy); else n_pass++;
        n_checks++; if (m_data !== 8'h00) $display("FAIL reset_m_data: got %h exp 00", m_data); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_streaming();
        for (int k = 1; k <= 16; k++) begin
            s_valid = 1'b1; s_data = 8'(k); m_ready = 1'b1;
            step();
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== 8'(k) || occupancy !== 2'd1)
                $display("FAIL stream_%0d: got v=%b d=%h occ=%0d exp v=1 d=%h occ=1", k, m_valid, m_data, occupancy, 8'(k));
            else n_pass++;
        end
        s_valid = 1'b0;
        step();
        n_checks++; if (m_valid !== 1'b0 || occupancy !== 2'd0) $display("FAIL stream_drain: got v=%b occ=%0d exp v=0 occ=0", m_valid, occupancy); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [7:0] words [3];
        words[0] = 8'hA1; words[1] = 8'hA2; words[2] = 8'hA3;
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1; s_data = words[k];
            step();
        end
        n_checks++; if (s_ready !== 1'b0) $display("FAIL bp_s_ready: got %b exp 0", s_ready); else n_pass++;
        n_checks++; if (occupancy !== 2'd2) $display("FAIL bp_occ: got %0d exp 2", occupancy); else n_pass++;
        n_checks++; if (m_data !== 8'hA1) $display("FAIL bp_head: got %h exp a1", m_data); else n_pass++;
        m_ready = 1'b1;
        step();
        n_checks++; if (m_data !== 8'hA2 || occupancy !== 2'd1) $display("FAIL bp_second: got d=%h occ=%0d exp d=a2 occ=1", m_data, occupancy); else n_pass++;
        step();
        n_checks++; if (m_data !== 8'hA3 || m_valid !== 1'b1) $display("FAIL bp_third: got d=%h v=%b exp d=a3 v=1", m_data, m_valid); else n_pass++;
        s_valid = 1'b0;
        step();
        n_checks++; if (m_valid !== 1'b0) $display("FAIL bp_no_dup: got v=%b exp 0", m_valid); else n_pass++;
    endtask

    task automatic test_simultaneous();
        m_ready = 1'b0; s_valid = 1'b1; s_data = 8'h55;
        step();
        n_checks++; if (m_data !== 8'h55 || occupancy !== 2'd1) $display("FAIL sim_hold: got d=%h occ=%0d exp d=55 occ=1", m_data, occupancy); else n_pass++;
        m_ready = 1'b1; s_data = 8'h66;
        step();
        n_checks++; if (m_data !== 8'h66 || occupancy !== 2'd1) $display("FAIL sim_pass: got d=%h occ=%0d exp d=66 occ=1", m_data, occupancy); else n_pass++;
        s_valid = 1'b0;
        step();
    endtask

    task automatic test_flush();
        m_ready = 1'b0; s_valid = 1'b1;
        s_data = 8'hB0; step();
        s_data = 8'hB1; step();
        n_checks++; if (occupancy !== 2'd2) $display("FAIL flush_pre_occ: got %0d exp 2", occupancy); else n_pass++;
        flush = 1'b1; s_data = 8'hB2; m_ready = 1'b1;
        step();
        flush = 1'b0; s_valid = 1'b0;
        n_checks++; if (m_valid !== 1'b0 || occupancy !== 2'd0) $display("FAIL flush_clear: got v=%b occ=%0d exp v=0 occ=0", m_valid, occupancy); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++; if (m_valid !== 1'b0) $display("FAIL flush_leak_%0d: got v=%b d=%h exp v=0", k, m_valid, m_data); else n_pass++;
        end
    endtask

    task automatic test_reset_midstream();
        m_ready = 1'b0; s_valid = 1'b1;
        s_data = 8'hC0; step();
        s_data = 8'hC1; step();
        n_checks++; if (occupancy !== 2'd2) $display("FAIL rst_pre_occ: got %0d exp 2", occupancy); else n_pass++;
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        n_checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || occupancy !== 2'd0 || m_data !== 8'h00)
            $display("FAIL rst_async: got v=%b r=%b occ=%0d d=%h exp v=0 r=1 occ=0 d=00", m_valid, s_ready, occupancy, m_data);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        s_valid = 1'b1; s_data = 8'h11; m_ready = 1'b0;
        step();
        n_checks++; if (m_valid !== 1'b1 || m_data !== 8'h11) $display("FAIL rst_first_word: got v=%b d=%h exp v=1 d=11", m_valid, m_data); else n_pass++;
        s_valid = 1'b0; m_ready = 1'b1;
        step();
    endtask

    task automatic test_soak();
        bit         prev_hold;
        logic [7:0] prev_data;
        logic       r_before;
        prev_hold = 1'b0;
        prev_data = '0;
        for (int c = 0; c < 10000; c++) begin
            s_valid = ($urandom_range(0, 9) < 7);
            s_data  = 8'($urandom);
            m_ready = ($urandom_range(0, 9) < 6);
            flush   = ($urandom_range(0, 63) == 0);
            #0;
            n_checks++;
            if (occupancy !== 2'(q.size()) || m_valid !== (q.size() > 0) || s_ready !== (q.size() < 2))
                $display("FAIL soak_ctrl_%0d: got occ=%0d v=%b r=%b exp occ=%0d", c, occupancy, m_valid, s_ready, q.size());
            else n_pass++;
            if (q.size() > 0) begin
                n_checks++;
                if (m_data !== q[0]) $display("FAIL soak_data_%0d: got %h exp %h", c, m_data, q[0]);
                else n_pass++;
            end
            if (prev_hold) begin
                n_checks++;
                if (m_valid !== 1'b1 || m_data !== prev_data)
                    $display("FAIL soak_stable_%0d: got v=%b d=%h exp v=1 d=%h", c, m_valid, m_data, prev_data);
                else n_pass++;
            end
            if (c % 97 == 0) begin
                r_before = s_ready;
                m_ready = ~m_ready;
                #1;
                n_checks++;
                if (s_ready !== r_before) $display("FAIL soak_ready_path_%0d: got %b exp %b", c, s_ready, r_before);
                else n_pass++;
                m_ready = ~m_ready;
                #1;
            end
            prev_hold = m_valid && !m_ready && !flush;
            prev_data = m_data;
            step();
        end
        flush = 1'b0; s_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_reset_midstream();
        test_soak();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
